// File: rtl/mem_if.sv
// Request/response bus between the datapath (master) and the memory responder (slave).
`default_nettype none

interface mem_if #(
   parameter int unsigned WIDTH = 16
);
   logic             req_valid;
   logic             req_write;
   logic [WIDTH-1:0] req_addr;
   logic [WIDTH-1:0] req_wdata;
   logic             req_ready;
   logic             rsp_valid;
   logic [WIDTH-1:0] rsp_rdata;
   logic             rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// +--------------------------------------------------------------------------+
// | mem_responder: single-word memory responder, RAM + one I/O register,    |
// |                programmable wait states, ready/valid handshake.          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_responder #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned ADDR_BITS   = 10,
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned IO_ADDR     = 16'hFFFF
) (
   input  wire logic             clk,
   input  wire logic             reset,
   mem_if.slave                  bus,
   input  wire logic [WIDTH-1:0] io_in,
   output logic      [WIDTH-1:0] io_out
);

   localparam logic [1:0]       c_IDLE      = 2'd0;
   localparam logic [1:0]       c_WAIT      = 2'd1;
   localparam logic [1:0]       c_RESP      = 2'd2;
   localparam logic [3:0]       c_WAIT_LOAD = 4'(WAIT_STATES);
   localparam logic [WIDTH-1:0] c_IO_ADDR   = WIDTH'(IO_ADDR);
   localparam int unsigned      c_DEPTH     = 2 ** ADDR_BITS;

   generate
      if (WAIT_STATES > 15) begin : g_wait_states_illegal
         $error("mem_responder: WAIT_STATES must be in 0..15");
      end
   endgenerate

   logic [1:0]       r_state;
   logic [3:0]       r_cnt;
   logic             r_write;
   logic [WIDTH-1:0] r_addr;
   logic [WIDTH-1:0] r_wdata;
   logic [WIDTH-1:0] r_rsp_rdata;
   logic             r_rsp_err;
   logic [WIDTH-1:0] r_io_out;
   logic [WIDTH-1:0] r_mem [0:c_DEPTH-1];

   logic             w_accept;
   logic             w_commit;
   logic             w_c_write;
   logic [WIDTH-1:0] w_c_addr;
   logic [WIDTH-1:0] w_c_wdata;
   logic             w_in_ram;
   logic             w_is_io;

   assign w_accept = (r_state == c_IDLE) && bus.req_valid;

   // With zero wait states the accept edge is also the commit edge, so the
   // live request fields are used instead of the not-yet-latched copies.
   assign w_commit  = (w_accept && (WAIT_STATES == 0)) ||
                      ((r_state == c_WAIT) && (r_cnt == 4'd1));
   assign w_c_write = (r_state == c_IDLE) ? bus.req_write : r_write;
   assign w_c_addr  = (r_state == c_IDLE) ? bus.req_addr  : r_addr;
   assign w_c_wdata = (r_state == c_IDLE) ? bus.req_wdata : r_wdata;

   assign w_in_ram = (w_c_addr >> ADDR_BITS) == '0;
   assign w_is_io  = (w_c_addr == c_IO_ADDR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= c_IDLE;
         r_cnt       <= 4'd0;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_io_out    <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (bus.req_valid) begin
                  r_write <= bus.req_write;
                  r_addr  <= bus.req_addr;
                  r_wdata <= bus.req_wdata;
                  r_cnt   <= c_WAIT_LOAD;
                  r_state <= (WAIT_STATES == 0) ? c_RESP : c_WAIT;
               end
            end
            c_WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state <= c_RESP;
               end
            end
            c_RESP:  r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase

         if (w_commit) begin
            r_rsp_err   <= !(w_in_ram || w_is_io);
            r_rsp_rdata <= '0;
            if (w_c_write) begin
               if (w_in_ram) begin
                  r_mem[w_c_addr[ADDR_BITS-1:0]] <= w_c_wdata;
               end else if (w_is_io) begin
                  r_io_out <= w_c_wdata;
               end
            end else begin
               if (w_in_ram) begin
                  r_rsp_rdata <= r_mem[w_c_addr[ADDR_BITS-1:0]];
               end else if (w_is_io) begin
                  r_rsp_rdata <= io_in;
               end
            end
         end
      end
   end

   assign bus.req_ready = (r_state == c_IDLE);
   assign bus.rsp_valid = (r_state == c_RESP);
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;
   assign io_out        = r_io_out;

endmodule

`default_nettype wire
